approx_adder_err_monitor: RTL and testbench

Sequential error-monitoring stage placed directly downstream of the 2-bit + 2-bit approximate adders (4 inputs, 3-bit sum). For each operand pair it receives the approximate sum, computes the exact sum, and accumulates error statistics over a fixed window of samples. At the end of each window it emits a report: sample count, violation count, maximum absolute error, sum of absolute errors, and a pass flag. The report is checked against the error threshold the approximation was synthesised for (default ET = 5).

---
 rtl/approx_adder_err_monitor.sv | 81 ++++++++
 tb/tb_approx_adder_err_monitor.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/approx_adder_err_monitor.sv
// approx_adder_err_monitor: windowed error statistics for a 2b+2b approximate adder.
module approx_adder_err_monitor #(
    parameter int unsigned ET    = 5,
    parameter int unsigned WIN   = 16,
    parameter int unsigned CNT_W = $clog2(WIN + 1),
    parameter int unsigned SUM_W = $clog2(7 * WIN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [1:0]       s_a,
    input  logic [1:0]       s_b,
    input  logic [2:0]       s_approx,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] m_count,
    output logic [CNT_W-1:0] m_viol,
    output logic [2:0]       m_max_err,
    output logic [SUM_W-1:0] m_sum_err,
    output logic             m_pass,
    output logic             sticky_fail
);
    typedef enum logic {COLLECT, REPORT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN);
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, viol_q, viol_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [2:0]       max_q, max_d, exact, err;
    logic             viol;
    assign exact   = {1'b0, s_a} + {1'b0, s_b};
    assign err     = exact >= s_approx ? exact - s_approx : s_approx - exact;
    assign viol    = {29'd0, err} > ET;
    assign cnt_d   = cnt_q + CNT_W'(1);
    assign viol_d  = viol_q + CNT_W'(viol);
    assign sum_d   = sum_q + SUM_W'(err);
    assign max_d   = err > max_q ? err : max_q;
    assign s_ready = state_q == COLLECT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            viol_q      <= '0;
            sum_q       <= '0;
            max_q       <= '0;
            sticky_fail <= 1'b0;
            m_valid     <= 1'b0;
            m_count     <= '0;
            m_viol      <= '0;
            m_max_err   <= '0;
            m_sum_err   <= '0;
            m_pass      <= 1'b0;
        end else if (state_q == COLLECT) begin
            if (s_valid) begin
                cnt_q       <= cnt_d;
                viol_q      <= viol_d;
                sum_q       <= sum_d;
                max_q       <= max_d;
                sticky_fail <= sticky_fail | viol;
                // The window-closing accept publishes its own contribution.
                if (cnt_d == LAST) begin
                    state_q   <= REPORT;
                    m_valid   <= 1'b1;
                    m_count   <= cnt_d;
                    m_viol    <= viol_d;
                    m_max_err <= max_d;
                    m_sum_err <= sum_d;
                    m_pass    <= viol_d == '0;
                end
            end
        end else if (m_ready) begin
            state_q <= COLLECT;
            m_valid <= 1'b0;
            cnt_q   <= '0;
            viol_q  <= '0;
            sum_q   <= '0;
            max_q   <= '0;
        end
    end
endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// tb_approx_adder_err_monitor: directed checks of window statistics, backpressure, clear and reset.
module tb_approx_adder_err_monitor;
    logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    logic       s_valid = 1'b0, s_valid1 = 1'b0, m_ready = 1'b1;
    logic [1:0] s_a = '0, s_b = '0;
    logic [2:0] s_approx = '0;
    logic       s_ready, m_valid, m_pass, sticky_fail;
    logic [4:0] m_count, m_viol;
    logic [2:0] m_max_err;
    logic [6:0] m_sum_err;
    logic       s_ready1, m_valid1, m_pass1, sticky1;
    logic [0:0] m_count1, m_viol1;
    logic [2:0] m_max_err1, m_sum_err1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    approx_adder_err_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .s_approx(s_approx), .m_valid(m_valid), .m_ready(m_ready),
        .m_count(m_count), .m_viol(m_viol), .m_max_err(m_max_err), .m_sum_err(m_sum_err),
        .m_pass(m_pass), .sticky_fail(sticky_fail)
    );

    approx_adder_err_monitor #(.WIN(1)) u_win1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid1), .s_ready(s_ready1),
        .s_a(s_a), .s_b(s_b), .s_approx(s_approx), .m_valid(m_valid1), .m_ready(1'b1),
        .m_count(m_count1), .m_viol(m_viol1), .m_max_err(m_max_err1), .m_sum_err(m_sum_err1),
        .m_pass(m_pass1), .sticky_fail(sticky1)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [2:0] ap);
        s_valid  = 1'b1;
        s_a      = a;
        s_b      = b;
        s_approx = ap;
        check("s_ready_on_send", s_ready, 1);
        step();
    endtask

    task automatic report(input string tag, input int cnt, input int vl, input int mx,
                          input int sm, input int ps);
        check({tag, "_valid"}, m_valid, 1);
        check({tag, "_count"}, m_count, cnt);
        check({tag, "_viol"}, m_viol, vl);
        check({tag, "_max"}, m_max_err, mx);
        check({tag, "_sum"}, m_sum_err, sm);
        check({tag, "_pass"}, m_pass, ps);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_sticky", sticky_fail, 0);
        check("rst_m_count", m_count, 0);
        check("rst_m_sum", m_sum_err, 0);
        check("rst_m_pass", m_pass, 0);

        // exact sweep of all 16 operand pairs
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("sweep_valid_early", m_valid, 0);
            send(2'(i >> 2), 2'(i), 3'((i >> 2) + (i & 3)));
        end
        s_valid = 1'b0;
        report("sweep", 16, 0, 0, 0, 1);
        check("sweep_s_ready_busy", s_ready, 0);
        step();
        check("sweep_restart_ready", s_ready, 1);
        check("sweep_valid_drop", m_valid, 0);

        // threshold boundary: err 5 passes, err 6 violates
        send(2'd3, 2'd2, 3'd0);
        check("thr_sticky_err5", sticky_fail, 0);
        send(2'd3, 2'd3, 3'd0);
        check("thr_sticky_err6", sticky_fail, 1);
        for (int i = 0; i < 14; i++) send(2'd1, 2'd1, 3'd2);
        s_valid = 1'b0;
        report("thr", 16, 1, 6, 11, 0);
        step();

        // overestimate in a one-sample window
        s_a = 2'd0; s_b = 2'd0; s_approx = 3'd7; s_valid1 = 1'b1;
        step();
        s_valid1 = 1'b0;
        check("win1_valid", m_valid1, 1);
        check("win1_count", m_count1, 1);
        check("win1_max", m_max_err1, 7);
        check("win1_sum", m_sum_err1, 7);
        check("win1_viol", m_viol1, 1);
        check("win1_sticky", sticky1, 1);

        // backpressure: report held for 5 cycles while samples wait
        m_ready = 1'b0;
        send(2'd0, 2'd0, 3'd1);
        for (int i = 1; i < 16; i++) send(2'(i >> 2), 2'(i), 3'((i >> 2) + (i & 3)));
        s_a = 2'd3; s_b = 2'd3; s_approx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            check("bp_s_ready", s_ready, 0);
            report("bp", 16, 0, 1, 1, 1);
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        check("bp_ready_after", s_ready, 1);
        check("bp_valid_after", m_valid, 0);

        // clear mid-window discards the partial window and its sample
        for (int i = 0; i < 6; i++) send(2'd2, 2'd1, 3'd3);
        send(2'd3, 2'd3, 3'd0);
        check("clr_sticky_before", sticky_fail, 1);
        clear = 1'b1;
        send(2'd3, 2'd3, 3'd0);
        clear = 1'b0;
        check("clr_sticky", sticky_fail, 0);
        check("clr_m_count", m_count, 0);
        check("clr_m_valid", m_valid, 0);
        send(2'd1, 2'd0, 3'd3);
        for (int i = 0; i < 14; i++) send(2'd0, 2'd2, 3'd2);
        check("clr_not_early", m_valid, 0);
        send(2'd0, 2'd2, 3'd2);
        s_valid = 1'b0;
        report("clr", 16, 0, 2, 2, 1);
        check("clr_sticky_after", sticky_fail, 0);

        // async reset while a report is pending
        m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 0);
        check("arst_s_ready", s_ready, 1);
        check("arst_m_count", m_count, 0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        send(2'd0, 2'd0, 3'd3);
        for (int i = 0; i < 15; i++) send(2'd1, 2'd2, 3'd3);
        s_valid = 1'b0;
        report("arst_win", 16, 0, 3, 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
